// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I funct3
// encodings, the handshake FSM states and the funct3 legality rule.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Stores only know B/H/W; loads reject the three unassigned encodings.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    else    return funct3 inside {3'b011, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the memory stage (master) and the data
// memory (slave). One transaction is outstanding at a time.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
) ();

  logic              iReq;
  logic              oReady;
  logic              iWe;
  logic [2:0]        iFunct3;
  logic [ADDR_W-1:0] iAddress;
  logic [31:0]       iWriteData;
  logic              oRespValid;
  logic              iRespReady;
  logic [31:0]       oReadData;
  logic              oError;

  modport master (
    output iReq, iWe, iFunct3, iAddress, iWriteData, iRespReady,
    input  oReady, oRespValid, oReadData, oError
  );

  modport slave (
    input  iReq, iWe, iFunct3, iAddress, iWriteData, iRespReady,
    output oReady, oRespValid, oReadData, oError
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit word array: builds the store byte enables
// and lane-shifted store data, flags misalignment, and extracts/extends the
// load result from a full word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // Move the addressed byte/halfword down to bit 0 for extension.
  assign lane = load_word >> {addr_lo, 3'b000};

  // Store side: width from funct3[1:0], position from addr_lo.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    byte_en    = 4'b0000;
    misaligned = 1'b0;
    store_word = store_data << {addr_lo, 3'b000};
    case (funct3[1:0])
      2'b00: byte_en = 4'b0001 << addr_lo;
      2'b01: begin
        byte_en    = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      2'b10: begin
        byte_en    = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // Load side: sign- or zero-extend the selected lane.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_W:    load_data = load_word;
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_HU:   load_data = {16'd0, lane[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Clocked RV32I data memory with a valid/ready request and a held response.
// Stores commit at the accept edge; loads read the word at the accept edge
// and present the extended result READ_LATENCY cycles later. Misaligned,
// out-of-range and illegal-funct3 accesses answer with an error after one
// cycle and never touch the array.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 512,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input logic          iClk,
  input logic          iRst,
  data_mem_lsu_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 2;  // counts READ_LATENCY-1, at most 3
  localparam logic [ADDR_W:0] BYTE_SPAN = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic        accept;
  logic        fault;
  logic        out_of_range;
  logic        misaligned;
  logic [IDX_W-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] read_data;
  logic        error;

  assign accept       = bus.iReq && (state == ST_IDLE);
  assign idx          = bus.iAddress[IDX_W+1:2];
  // Full-width compare so high address bits can never alias into the array.
  assign out_of_range = ({1'b0, bus.iAddress} >= BYTE_SPAN);
  assign fault        = misaligned || out_of_range || funct3_illegal(bus.iWe, bus.iFunct3);
  assign load_word    = mem[idx];

  mem_lane_align u_align (
    .funct3     (bus.iFunct3),
    .addr_lo    (bus.iAddress[1:0]),
    .store_data (bus.iWriteData),
    .load_word  (load_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  // State register.
  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (iRst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state: good loads with extra latency wait, everything else answers next cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!bus.iWe && !fault && (READ_LATENCY > 1)) state_next = ST_WAIT;
          else                                          state_next = ST_RESP;
        end
      end
      ST_WAIT: if (cnt == CNT_W'(1)) state_next = ST_RESP;
      ST_RESP: if (bus.iRespReady) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latency counter and response registers, captured once at accept.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt       <= '0;
      read_data <= '0;
      error     <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_W'(READ_LATENCY - 1);
      error     <= fault;
      read_data <= (fault || bus.iWe) ? 32'd0 : load_data;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Byte-lane write of accepted, non-faulting stores.
  always_ff @(posedge iClk) begin
    // NOTE: the array is deliberately not reset; software must write before it reads.
    if (!iRst && accept && bus.iWe && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  assign bus.oReady     = (state == ST_IDLE);
  assign bus.oRespValid = (state == ST_RESP);
  assign bus.oReadData  = read_data;
  assign bus.oError     = error;

endmodule
